cmd_parser: RTL

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cmd_parser.sv
// Byte-stream command parser: assembles SYNC/opcode/addr/[data]/checksum frames
// into 24-bit command words for a FIFO and tracks rejected frames.
module cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        baud_tick,
  input  logic        cmd_fifo_full,
  output logic [23:0] cmd_fifo_wr_data,
  output logic        cmd_fifo_wr_en,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        overflow
);

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPCODE,
    S_ADDR,
    S_DATA,
    S_CSUM
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] tmo_q, tmo_d;
  logic        wr_en_q, wr_en_d;
  logic [23:0] wr_data_q, wr_data_d;
  logic        frame_err_q;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        overflow_q, overflow_d;

  logic        reject;
  logic        timeout;
  logic [7:0]  csum_exp;

  // data_q is cleared on every opcode, so reads fold in 8'h00 automatically.
  assign csum_exp = opcode_q ^ addr_q ^ data_q;
  assign timeout  = (state_q != S_IDLE) && (tmo_q >= TIMEOUT_TICKS);

  // NOTE: every signal driven here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    overflow_d = overflow_q;
    reject     = 1'b0;

    if (rx_valid) begin
      // An arriving byte always wins over a simultaneous timeout.
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = S_OPCODE;
        end
        S_OPCODE: begin
          if (rx_data == OP_READ || rx_data == OP_WRITE) begin
            opcode_d = rx_data;
            data_d   = '0;
            state_d  = S_ADDR;
          end else begin
            reject  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_ADDR: begin
          addr_d  = rx_data;
          state_d = (opcode_q == OP_WRITE) ? S_DATA : S_CSUM;
        end
        S_DATA: begin
          data_d  = rx_data;
          state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          if (rx_data == csum_exp) begin
            if (cmd_fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_data_d = {opcode_q, addr_q, data_q};
            end
          end else begin
            reject = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timeout) begin
      state_d = S_IDLE;
      tmo_d   = '0;
      reject  = 1'b1;
    end else if (baud_tick && state_q != S_IDLE) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (reject && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= reject;
      err_cnt_q   <= err_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign cmd_fifo_wr_en   = wr_en_q;
  assign cmd_fifo_wr_data = wr_data_q;
  assign frame_err        = frame_err_q;
  assign err_cnt          = err_cnt_q;
  assign overflow         = overflow_q;

endmodule
